// File: rtl/spi_temp_scanner.sv
// spi_temp_scanner: SPI master that round-robins several temperature sensors on a shared bus
// and tracks a hysteretic over-temperature alarm per channel.
module spi_temp_scanner #(
  parameter int NUM_CH     = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic [DATA_BITS-1:0] thresh_hi,
  input  logic [DATA_BITS-1:0] thresh_lo,
  input  logic                 sio,
  output logic                 sck,
  output logic [NUM_CH-1:0]    cs_n,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic [CH_W-1:0]      data_ch,
  output logic                 data_valid,
  output logic [NUM_CH-1:0]    alarm
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [CH_W-1:0]       ch;
  logic [CH_W-1:0]       nxt_ch;
  logic [FRAME_BITS-1:0] sr;
  logic [DATA_BITS-1:0]  word;
  logic                  div_done;
  logic                  last_bit;
  logic                  last_ch;
  logic                  alarm_nxt;
  assign div_done = div_cnt == DIV_W'(CLK_DIV - 1);
  assign last_bit = bit_cnt == BIT_W'(FRAME_BITS - 1);
  assign last_ch  = ch == CH_W'(NUM_CH - 1);
  assign nxt_ch   = last_ch ? '0 : ch + 1'b1;
  assign word     = sr[FRAME_BITS-1 -: DATA_BITS];
  // set is tested first so it wins when the thresholds overlap
  assign alarm_nxt = $signed(word) >= $signed(thresh_hi) ? 1'b1 :
                     $signed(word) <  $signed(thresh_lo) ? 1'b0 : alarm[ch];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sck        <= 1'b0;
      cs_n       <= '1;
      busy       <= 1'b0;
      data_out   <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      alarm      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ch         <= '0;
      sr         <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (start || auto_en) begin
          state   <= SETUP;
          ch      <= '0;
          cs_n    <= ~NUM_CH'(1);
          busy    <= 1'b1;
          div_cnt <= '0;
        end
        SETUP: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
          if (div_done) begin
            state   <= SHIFT;
            sck     <= 1'b1;
            sr      <= FRAME_BITS'({sr, sio});
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          div_cnt <= div_done ? '0 : div_cnt + 1'b1;
          if (div_done && sck)
            sck <= 1'b0;
          else if (div_done && !last_bit) begin
            sck     <= 1'b1;
            sr      <= FRAME_BITS'({sr, sio});
            bit_cnt <= bit_cnt + 1'b1;
          end else if (div_done) begin
            state      <= GAP;
            cs_n       <= '1;
            data_out   <= word;
            data_ch    <= ch;
            data_valid <= 1'b1;
            alarm[ch]  <= alarm_nxt;
            gap_cnt    <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            if (!last_ch || auto_en) begin
              state   <= SETUP;
              ch      <= nxt_ch;
              cs_n    <= ~(NUM_CH'(1) << nxt_ch);
              div_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
